// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types, constants and layer mapping for the NTT sequencer
package ntt_pkg;

  localparam int N                = 256;
  localparam int N_BF             = 128;
  localparam int KYBER_LAYERS     = 7;
  localparam int DILITHIUM_LAYERS = 8;
  localparam int ADDR_W           = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } ntt_state_e;

  // Forward walks len from 128 downwards; inverse walks the same lens upwards,
  // starting at len=2 for Kyber and len=1 for Dilithium.
  function automatic logic [2:0] layer_lenlog(input logic [2:0] layer,
                                              input logic       kyber,
                                              input logic       inverse);
    logic [2:0] lenlog;
    if (inverse) begin
      lenlog = layer + {2'b00, kyber};
    end else begin
      lenlog = 3'd7 - layer;
    end
    return lenlog;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - maps butterfly index and layer to coefficient pair and twiddle index
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [6:0]        bf_i,
  input  logic [2:0]        lenlog_i,
  input  logic              inverse_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [7:0]        tw_idx_o
);

  logic [7:0] w_bf;
  logic [7:0] w_len;
  logic [7:0] w_grp;
  logic [7:0] w_off;
  logic [3:0] w_span_log;
  logic [7:0] w_m;
  logic [7:0] w_two_m_minus1;
  logic [7:0] w_a;

  // Split bf into group/offset, place the pair two len apart, and pick the twiddle.
  // 2m-1 is formed as 0xFF>>lenlog so the inverse index never needs a ninth bit.
  always_comb begin
    w_bf           = {1'b0, bf_i};
    w_len          = 8'd1 << lenlog_i;
    w_grp          = w_bf >> lenlog_i;
    w_off          = w_bf & (w_len - 8'd1);
    w_span_log     = {1'b0, lenlog_i} + 4'd1;
    w_m            = 8'd128 >> lenlog_i;
    w_two_m_minus1 = 8'hff >> lenlog_i;
    w_a            = (w_grp << w_span_log) | w_off;
    addr_a_o       = w_a;
    addr_b_o       = w_a + w_len;
    if (inverse_i) begin
      tw_idx_o = w_two_m_minus1 - w_grp;
    end else begin
      tw_idx_o = w_m + w_grp;
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - sequences the butterfly datapath through a full in-place NTT/INTT
module ntt_ctrl #(
  parameter int PIPE_LAT = 3,
  parameter int ADDR_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              inverse_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [7:0]        tw_idx_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_a_o,
  output logic [ADDR_W-1:0] wr_addr_b_o,
  output logic              sel_red_o,
  output logic              sel_butterfly_o
);

  import ntt_pkg::*;

  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);
  localparam logic [6:0] BF_LAST    = 7'(N_BF - 1);

  ntt_state_e        r_state;
  ntt_state_e        w_state_nxt;
  logic [6:0]        r_bf;
  logic [6:0]        w_bf_nxt;
  logic [2:0]        r_layer;
  logic [2:0]        w_layer_nxt;
  logic [3:0]        r_drain;
  logic [3:0]        w_drain_nxt;
  logic              r_mode;
  logic              w_mode_nxt;
  logic              r_inverse;
  logic              w_inverse_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_issue;
  logic              w_flush;
  logic [6:0]        w_issue_bf;
  logic [2:0]        w_issue_layer;
  logic [2:0]        w_issue_lenlog;
  logic [2:0]        w_last_layer;
  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] w_b;
  logic [7:0]        w_tw;

  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_a;
  logic [ADDR_W-1:0] r_rd_b;
  logic [7:0]        r_tw;

  logic              r_pipe_en [PIPE_LAT];
  logic [ADDR_W-1:0] r_pipe_a  [PIPE_LAT];
  logic [ADDR_W-1:0] r_pipe_b  [PIPE_LAT];

  assign w_last_layer   = r_mode ? 3'(KYBER_LAYERS - 1) : 3'(DILITHIUM_LAYERS - 1);
  assign w_issue_lenlog = layer_lenlog(w_issue_layer, w_mode_nxt, w_inverse_nxt);

  ntt_addr_gen u_addr_gen (
    .bf_i      (w_issue_bf),
    .lenlog_i  (w_issue_lenlog),
    .inverse_i (w_inverse_nxt),
    .addr_a_o  (w_a),
    .addr_b_o  (w_b),
    .tw_idx_o  (w_tw)
  );

  // Next-state logic: the start edge itself issues bf 0, so RUN after IDLE begins at bf 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_bf_nxt      = r_bf;
    w_layer_nxt   = r_layer;
    w_drain_nxt   = r_drain;
    w_mode_nxt    = r_mode;
    w_inverse_nxt = r_inverse;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_issue       = 1'b0;
    w_issue_bf    = r_bf;
    w_issue_layer = r_layer;
    w_flush       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_mode_nxt    = mode_i;
          w_inverse_nxt = inverse_i;
          w_issue       = 1'b1;
          w_issue_bf    = '0;
          w_issue_layer = '0;
          w_bf_nxt      = 7'd1;
          w_layer_nxt   = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        w_issue  = 1'b1;
        w_bf_nxt = r_bf + 7'd1;
        if (r_bf == BF_LAST) begin
          w_drain_nxt = '0;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          if (r_layer == w_last_layer) begin
            w_state_nxt = S_DONE;
          end else begin
            w_layer_nxt = r_layer + 3'd1;
            w_state_nxt = S_RUN;
          end
        end else begin
          w_drain_nxt = r_drain + 4'd1;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_flush     = 1'b1;
    end
  end

  // State, counters, latched command and status flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_bf      <= '0;
      r_layer   <= '0;
      r_drain   <= '0;
      r_mode    <= 1'b0;
      r_inverse <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bf      <= w_bf_nxt;
      r_layer   <= w_layer_nxt;
      r_drain   <= w_drain_nxt;
      r_mode    <= w_mode_nxt;
      r_inverse <= w_inverse_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Registered read strobe, addresses and twiddle; addresses hold between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
    end else begin
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_rd_a <= w_a;
        r_rd_b <= w_b;
        r_tw   <= w_tw;
      end
    end
  end

  // Write-back delay line; abort kills every in-flight strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pipe_en[i] <= 1'b0;
        r_pipe_a[i]  <= '0;
        r_pipe_b[i]  <= '0;
      end
    end else if (w_flush) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pipe_en[i] <= 1'b0;
      end
    end else begin
      r_pipe_en[0] <= r_rd_en;
      r_pipe_a[0]  <= r_rd_a;
      r_pipe_b[0]  <= r_rd_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipe_en[i] <= r_pipe_en[i-1];
        r_pipe_a[i]  <= r_pipe_a[i-1];
        r_pipe_b[i]  <= r_pipe_b[i-1];
      end
    end
  end

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign rd_en_o         = r_rd_en;
  assign rd_addr_a_o     = r_rd_a;
  assign rd_addr_b_o     = r_rd_b;
  assign tw_idx_o        = r_tw;
  assign wr_en_o         = r_pipe_en[PIPE_LAT-1];
  assign wr_addr_a_o     = r_pipe_a[PIPE_LAT-1];
  assign wr_addr_b_o     = r_pipe_b[PIPE_LAT-1];
  assign sel_red_o       = r_mode;
  assign sel_butterfly_o = r_inverse;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb/tb_ntt_ctrl.sv - scoreboard bench for the NTT sequencer
module tb_ntt_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
  } ev_t;

  localparam int BIG = 1000000;

  logic clk = 1'b0;
  int   cyc = 0;

  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       mode    = 1'b0;
  logic       inverse = 1'b0;
  logic       abort   = 1'b0;
  logic       busy, done, rd_en, wr_en, sel_red, sel_bf;
  logic [7:0] rd_a, rd_b, tw, wr_a, wr_b;

  logic       start1 = 1'b0;
  logic       mode1  = 1'b1;
  logic       inv1   = 1'b0;
  logic       abort1 = 1'b0;
  logic       busy1, done1, rd_en1, wr_en1, sel_red1, sel_bf1;
  logic [7:0] rd_a1, rd_b1, tw1, wr_a1, wr_b1;

  int   n_checks = 0;
  int   n_err    = 0;
  ev_t  rd_q[$];
  ev_t  wr_q[$];
  int   done_q[$];
  int   busy_lo = 1;
  int   busy_hi = 0;
  logic exp_mode = 1'b0;
  logic exp_inv  = 1'b0;
  logic exp_busy;
  int   base  = 0;
  int   base1 = 0;
  int   p1_wr = 0;
  int   p1_done_n = 0;
  int   p1_done_cyc = 0;
  logic p1_first_seen = 1'b0;
  ev_t  ev;
  int   dc;

  ntt_ctrl #(.PIPE_LAT(3), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode), .inverse_i(inverse),
    .abort_i(abort), .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_a_o(rd_a),
    .rd_addr_b_o(rd_b), .tw_idx_o(tw), .wr_en_o(wr_en), .wr_addr_a_o(wr_a),
    .wr_addr_b_o(wr_b), .sel_red_o(sel_red), .sel_butterfly_o(sel_bf)
  );

  ntt_ctrl #(.PIPE_LAT(1), .ADDR_W(8)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .mode_i(mode1), .inverse_i(inv1),
    .abort_i(abort1), .busy_o(busy1), .done_o(done1), .rd_en_o(rd_en1), .rd_addr_a_o(rd_a1),
    .rd_addr_b_o(rd_b1), .tw_idx_o(tw1), .wr_en_o(wr_en1), .wr_addr_a_o(wr_a1),
    .wr_addr_b_o(wr_b1), .sel_red_o(sel_red1), .sel_butterfly_o(sel_bf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference-style NTT loop nest: zeta index k runs continuously across layers.
  task automatic push_exp(input int b0, input logic kyber, input logic inv,
                          input int lat, input int cut);
    int  layers, k, len, n, rel;
    ev_t e;
    layers = kyber ? 7 : 8;
    k = inv ? (kyber ? 127 : 255) : 1;
    for (int l = 0; l < layers; l++) begin
      len = inv ? ((kyber ? 2 : 1) << l) : (128 >> l);
      n = 0;
      for (int s = 0; s < ntt_pkg::N; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          rel  = l * (128 + lat) + 1 + n;
          e.a  = 8'(j);
          e.b  = 8'(j + len);
          if (rel <= cut) begin
            e.cyc = b0 + rel;
            e.tw  = 8'(k);
            rd_q.push_back(e);
          end
          if (rel + lat <= cut) begin
            e.cyc = b0 + rel + lat;
            e.tw  = 8'd0;
            wr_q.push_back(e);
          end
          n++;
        end
        k = inv ? k - 1 : k + 1;
      end
    end
    rel      = layers * (128 + lat) + 1;
    busy_lo  = b0 + 1;
    exp_mode = kyber;
    exp_inv  = inv;
    if (rel <= cut) begin
      done_q.push_back(b0 + rel);
      busy_hi = b0 + rel - 1;
    end else begin
      busy_hi = b0 + cut;
    end
  endtask

  // Scoreboard: pop expected reads/writes/done at their cycle and compare.
  always @(negedge clk) begin
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      check("rd_missing", 64'(0), 64'(rd_q[0].cyc));
      ev = rd_q.pop_front();
    end
    if (rd_en) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'(cyc), 64'(0));
      end else begin
        ev = rd_q.pop_front();
        check("rd", {32'(cyc), rd_a, rd_b, tw}, {32'(ev.cyc), ev.a, ev.b, ev.tw});
      end
    end
    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      check("wr_missing", 64'(0), 64'(wr_q[0].cyc));
      ev = wr_q.pop_front();
    end
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 64'(cyc), 64'(0));
      end else begin
        ev = wr_q.pop_front();
        check("wr", {32'(cyc), wr_a, wr_b}, {32'(ev.cyc), ev.a, ev.b});
      end
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      check("done_missing", 64'(0), 64'(done_q[0]));
      dc = done_q.pop_front();
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 64'(cyc), 64'(0));
      end else begin
        dc = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(dc));
      end
    end
    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    check("busy", 64'(busy), 64'(exp_busy));
    if (exp_busy) begin
      check("sel", {sel_red, sel_bf}, {exp_mode, exp_inv});
    end
    if (wr_en1) p1_wr++;
    if (done1) begin
      p1_done_n++;
      p1_done_cyc = cyc;
    end
    if (rd_en1 && !p1_first_seen) begin
      p1_first_seen = 1'b1;
      check("p1_first_rd", {32'(cyc - base1), rd_a1, rd_b1, tw1}, {32'd1, 8'd0, 8'd128, 8'd1});
    end
  end

  // Caller sits on a negedge; that period is cycle 0 of the new transform.
  task automatic go(input logic kyber, input logic inv, input int cut, input logic with_p1);
    base    = cyc;
    mode    = kyber;
    inverse = inv;
    start   = 1'b1;
    if (with_p1) begin
      base1  = cyc;
      start1 = 1'b1;
    end
    push_exp(base, kyber, inv, 3, cut);
    @(negedge clk);
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      check("timeout_pending", 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'(0));
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, rd_en, rd_a, rd_b, tw, wr_en, wr_a, wr_b, sel_red, sel_bf}, 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Kyber forward alongside the PIPE_LAT=1 instance; mode/inverse changes and a
    // second start while busy must have no effect.
    go(1'b1, 1'b0, BIG, 1'b1);
    wait_rel(200);
    mode    = 1'b0;
    inverse = 1'b1;
    wait_rel(400);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2000);
    check("p1_wr_count", 64'(p1_wr), 64'(896));
    check("p1_done_cycle", 64'(p1_done_cyc - base1), 64'(904));
    check("p1_done_pulses", 64'(p1_done_n), 64'(1));

    go(1'b0, 1'b0, BIG, 1'b0);
    wait_idle(2000);

    go(1'b1, 1'b1, BIG, 1'b0);
    wait_idle(2000);

    // Abort at cycle 50, clean restart at cycle 60.
    go(1'b0, 1'b1, 50, 1'b0);
    wait_rel(50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rd_wr_off", {busy, rd_en, wr_en}, 64'(0));
    wait_rel(60);
    go(1'b0, 1'b1, BIG, 1'b0);
    wait_idle(2000);

    // Asynchronous reset mid-run.
    go(1'b1, 1'b0, 300, 1'b0);
    wait_rel(300);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outputs",
             {busy, done, rd_en, rd_a, rd_b, tw, wr_en, wr_a, wr_b, sel_red, sel_bf}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy, done, rd_en, wr_en}, 64'(0));
    go(1'b1, 1'b0, BIG, 1'b0);
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer that drives the shared `butterfly` datapath through a complete in-place 256-point NTT or inverse NTT, for Kyber (7 layers) or Dilithium (8 layers). It sits between the coefficient RAM, the twiddle ROM and `butterfly`. Each cycle it issues one butterfly's read addresses and twiddle index. It issues the matching write-back addresses after a fixed pipeline latency, and holds `sel_red`/`sel_butterfly` steady for the whole transform.

## Interface
- `PIPE_LAT`, default 3: cycles from `rd_en_o` to the matching `wr_en_o`, covering RAM read, butterfly and output register; legal range 1..8.
- `ADDR_W`, default 8: coefficient address width; fixed at 8 for n=256.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; asynchronous and active-low.
- `start_i`  in  1  begin transform; sampled only in IDLE.
- `mode_i`  in  1  1=Kyber, 0=Dilithium; latched at start.
- `inverse_i`  in  1  0=forward (CT), 1=inverse (GS); latched at start.
- `abort_i`  in  1  synchronous abort.
- `busy_o`  out  1  high from the cycle after start until done/abort.
- `done_o`  out  1  one-cycle pulse after the last write.
- `rd_en_o`  out  1  read strobe for the a/b pair.
- `rd_addr_a_o`, `rd_addr_b_o`  out  ADDR_W  read addresses.
- `tw_idx_o`  out  8  twiddle ROM index, aligned with the read.
- `wr_en_o`  out  1  write-back strobe.
- `wr_addr_a_o`, `wr_addr_b_o`  out  ADDR_W  write addresses.
- `sel_red_o`  out  1  to `butterfly.sel_red_i`; equals the latched `mode_i`.
- `sel_butterfly_o`  out  1  to `butterfly.sel_butterfly_i`; equals the latched `inverse_i`.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE + `start_i`: latch mode and inverse, load the first layer, go to RUN.
  - RUN: one butterfly per cycle, `bf` = 0..127. After `bf`=127, go to DRAIN.
  - DRAIN: wait PIPE_LAT cycles. Then load the next layer and go to RUN, or go to DONE if the last layer has finished.
  - DONE: `done_o`=1 for one cycle, then IDLE.
- **Layers** (lenlog = log2 len):
  - Forward: len = 128, 64, ... down to 2 (Kyber) or down to 1 (Dilithium).
  - Inverse: len runs in the reverse order.
- **Addresses** per butterfly:
  - g = bf >> lenlog; off = bf & (len-1).
  - a = (g << (lenlog+1)) | off; b = a + len.
- **Twiddle:** m = 128 >> lenlog. Forward: tw = m + g. Inverse: tw = 2m - 1 - g. Computed in 8 bits with no wrap.
- **Write pipeline:** a PIPE_LAT-deep shift register of {rd_en, a, b}. Its output drives `wr_en_o`/`wr_addr_*_o`.
- **Command handling:**
  - `start_i` outside IDLE is ignored.
  - `mode_i`/`inverse_i` changes mid-transform are ignored.
- **Abort** in any state other than IDLE:
  - Next cycle: IDLE, `busy_o`=0, `rd_en_o`=0.
  - The write pipeline is flushed: no further `wr_en_o`, no `done_o`.
- **Reset** (async, any time): state IDLE, pipeline cleared; every output 0, including `sel_red_o`, `sel_butterfly_o` and the address/index outputs.

## Timing
- Cycle 0: `start_i` sampled in IDLE. Cycle 1: first `rd_en_o`, `busy_o`=1.
- Layer L (0-based) reads occur in cycles L·(128+PIPE_LAT)+1 .. L·(128+PIPE_LAT)+128. Writes occur PIPE_LAT cycles after each read.
- The next layer's first read comes one cycle after the previous layer's last write. The RAM must give write-before-read visibility on the following cycle.
- `done_o` is at cycle layers·(128+PIPE_LAT)+1, the same cycle `busy_o` falls.
  - Kyber, PIPE_LAT=3: cycle 918.
  - Dilithium, PIPE_LAT=3: cycle 1049.
- All outputs are registered. `tw_idx_o` changes in the same cycle as `rd_addr_*_o`.

## Structure
- `ntt_pkg` holds:
  - the state enum;
  - N=256, N_BF=128;
  - KYBER_LAYERS=7, DILITHIUM_LAYERS=8;
  - ADDR_W.
- Sub-module `ntt_addr_gen`: combinational mapping from {bf, lenlog, inverse} to {a, b, tw}.
- The FSM, layer counter and write shift register stay in `ntt_ctrl`.

## Test plan
All scenarios use PIPE_LAT=3 unless stated.
- **Kyber forward:**
  - Cycle 1: a=0, b=128, tw=1. Cycle 2: a=1, b=129.
  - First read of the last layer: a=0, b=2, tw=64.
  - 896 `wr_en_o` pulses in total; `done_o` at cycle 918.
- **Dilithium forward:**
  - Last layer bf0: a=0, b=1, tw=128. bf127: a=254, b=255, tw=255.
  - `sel_red_o`=0 throughout; `done_o` at cycle 1049.
- **Kyber inverse:**
  - First read: a=0, b=2, tw=127. Last layer: a=0, b=128, tw=1.
  - `sel_butterfly_o`=1 throughout.
- **Drain boundary:** layer-0 last write at cycle 131 (wr a=127, b=255); layer-1 first read at cycle 132 (a=0, b=64, tw=2).
- **Abort and restart:**
  - `abort_i` at cycle 50 → `rd_en_o`=0 from cycle 51, no `wr_en_o` after cycle 51, no `done_o`.
  - `start_i` at cycle 60 restarts a clean transform.
- **Ignored start and mid-run reset:**
  - `start_i` pulsed at cycle 400 while busy → no effect.
  - `rst_n_i` low at cycle 300 → all outputs 0 immediately; IDLE after release.
  - Repeat with PIPE_LAT=1: Kyber `done_o` at cycle 904.
